// File: rtl/alert_responder.sv
// rtl/alert_responder.sv - alert responder FSM with debounced acknowledge, pulsed buzzer and escalation
//
// Purpose: arms the alert counter, rings a pulsed buzzer on each new alert,
// accepts a debounced acknowledge, escalates on an unacknowledged ring timeout,
// then holds off briefly before re-arming.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   arm        in   user arm request (level)
//   alert      in   alert from the alert counter
//   alert_off  in   alert-finished indication from the alert counter
//   ack_btn    in   raw acknowledge button (may bounce)
//   enable     out  enable to the alert counter (ARMED, RINGING)
//   buzzer     out  pulsed buzzer drive while RINGING
//   ring_led   out  high while RINGING
//   escalate   out  sticky unacknowledged-timeout flag
//   alert_cnt  out  saturating count of alert episodes
module alert_responder #(
  parameter int DEB_CYCLES = 3,
  parameter int BEEP_ON    = 2,
  parameter int BEEP_OFF   = 2,
  parameter int RING_MAX   = 20,
  parameter int HOLD_OFF   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       arm,
  input  logic       alert,
  input  logic       alert_off,
  input  logic       ack_btn,
  output logic       enable,
  output logic       buzzer,
  output logic       ring_led,
  output logic       escalate,
  output logic [3:0] alert_cnt
);

  localparam int BEEP_PER = BEEP_ON + BEEP_OFF;
  localparam int DEB_W    = $clog2(DEB_CYCLES + 1);
  localparam int PH_W     = $clog2(BEEP_PER + 1);
  localparam int RING_W   = $clog2(RING_MAX + 1);
  localparam int HOLD_W   = $clog2(HOLD_OFF + 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ARMED   = 2'd1;
  localparam logic [1:0] RINGING = 2'd2;
  localparam logic [1:0] HOLD    = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              alert_q;
  logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
  logic              ack_pulse_q, ack_pulse_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [RING_W-1:0] ring_cnt_q, ring_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              enable_q, enable_d;
  logic              buzzer_q, buzzer_d;
  logic              ring_led_q, ring_led_d;
  logic              escalate_q, escalate_d;
  logic [3:0]        alert_cnt_q, alert_cnt_d;
  logic              alert_rise;
  logic              ring_expire;

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    ring_cnt_d  = ring_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    escalate_d  = escalate_q;
    alert_cnt_d = alert_cnt_q;

    alert_rise = alert & ~alert_q;

    // Run-length counter parks at DEB_CYCLES so a held button pulses only once.
    if (!ack_btn) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q != DEB_W'(DEB_CYCLES)) begin
      deb_cnt_d = deb_cnt_q + DEB_W'(1);
    end else begin
      deb_cnt_d = deb_cnt_q;
    end
    ack_pulse_d = ack_btn && (deb_cnt_q == DEB_W'(DEB_CYCLES - 1));

    // ring_cnt_q holds completed RINGING cycles minus one on the closing edge.
    ring_expire = (state_q == RINGING) && (ring_cnt_q == RING_W'(RING_MAX - 1));

    case (state_q)
      IDLE: begin
        if (arm) state_d = ARMED;
      end
      ARMED: begin
        if (alert_rise) begin
          state_d    = RINGING;
          ring_cnt_d = '0;
          phase_d    = '0;
          if (alert_cnt_q != 4'd15) alert_cnt_d = alert_cnt_q + 4'd1;
        end else if (!arm) begin
          state_d = IDLE;
        end
      end
      RINGING: begin
        if (ring_cnt_q != RING_W'(RING_MAX)) ring_cnt_d = ring_cnt_q + RING_W'(1);
        phase_d = (phase_q == PH_W'(BEEP_PER - 1)) ? '0 : phase_q + PH_W'(1);
        if (ring_expire) escalate_d = 1'b1;
        if (ack_pulse_q || alert_off) begin
          state_d    = HOLD;
          hold_cnt_d = '0;
        end
      end
      default: begin
        if (hold_cnt_q == HOLD_W'(HOLD_OFF - 1)) begin
          state_d = arm ? ARMED : IDLE;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
    endcase

    // An acknowledge always wins over a same-edge timeout, in any state.
    if (ack_pulse_q) escalate_d = 1'b0;

    // Outputs are registered from the next state so they line up with it.
    enable_d   = (state_d == ARMED) || (state_d == RINGING);
    ring_led_d = (state_d == RINGING);
    buzzer_d   = (state_d == RINGING) && (phase_d < PH_W'(BEEP_ON));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      alert_q     <= 1'b0;
      deb_cnt_q   <= '0;
      ack_pulse_q <= 1'b0;
      phase_q     <= '0;
      ring_cnt_q  <= '0;
      hold_cnt_q  <= '0;
      enable_q    <= 1'b0;
      buzzer_q    <= 1'b0;
      ring_led_q  <= 1'b0;
      escalate_q  <= 1'b0;
      alert_cnt_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      alert_q     <= alert;
      deb_cnt_q   <= deb_cnt_d;
      ack_pulse_q <= ack_pulse_d;
      phase_q     <= phase_d;
      ring_cnt_q  <= ring_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      enable_q    <= enable_d;
      buzzer_q    <= buzzer_d;
      ring_led_q  <= ring_led_d;
      escalate_q  <= escalate_d;
      alert_cnt_q <= alert_cnt_d;
    end
  end

  assign enable    = enable_q;
  assign buzzer    = buzzer_q;
  assign ring_led  = ring_led_q;
  assign escalate  = escalate_q;
  assign alert_cnt = alert_cnt_q;

endmodule

// File: tb/tb_alert_responder.sv
// tb/tb_alert_responder.sv - self-checking bench for alert_responder
module tb_alert_responder;
  localparam int DEB  = 3;
  localparam int BON  = 2;
  localparam int BOFF = 2;
  localparam int RMAX = 20;
  localparam int HOFF = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic arm = 1'b0;
  logic alert = 1'b0;
  logic alert_off = 1'b0;
  logic ack_btn = 1'b0;
  logic enable, buzzer, ring_led, escalate;
  logic [3:0] alert_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alert_responder #(
    .DEB_CYCLES(DEB), .BEEP_ON(BON), .BEEP_OFF(BOFF), .RING_MAX(RMAX), .HOLD_OFF(HOFF)
  ) dut (
    .clk(clk), .rst(rst), .arm(arm), .alert(alert), .alert_off(alert_off),
    .ack_btn(ack_btn), .enable(enable), .buzzer(buzzer), .ring_led(ring_led),
    .escalate(escalate), .alert_cnt(alert_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0 idle, 1 armed, 2 ringing, 3 hold-off.
  int  m_mode = 0;
  int  m_prev_alert = 0;
  int  m_run = 0;
  int  m_pulse = 0;
  int  m_ring = 0;
  int  m_hold_left = 0;
  int  m_esc = 0;
  int  m_cnt = 0;
  bit  m_valid = 1'b0;

  task automatic model_step();
    int pulse_now;
    int rise;
    if (rst) begin
      m_mode = 0; m_prev_alert = 0; m_run = 0; m_pulse = 0;
      m_ring = 0; m_hold_left = 0; m_esc = 0; m_cnt = 0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      pulse_now = m_pulse;
      rise = (alert && !m_prev_alert) ? 1 : 0;
      m_run = ack_btn ? m_run + 1 : 0;
      if (m_run > 1000) m_run = 1000;
      m_pulse = (m_run == DEB) ? 1 : 0;
      case (m_mode)
        0: if (arm) m_mode = 1;
        1: begin
          if (rise != 0) begin
            m_mode = 2;
            m_ring = 1;
            m_cnt = (m_cnt < 15) ? m_cnt + 1 : 15;
          end else if (!arm) begin
            m_mode = 0;
          end
        end
        2: begin
          if (m_ring == RMAX) m_esc = 1;
          if (pulse_now != 0 || alert_off) begin
            m_mode = 3;
            m_hold_left = HOFF;
          end else begin
            m_ring++;
          end
        end
        default: begin
          m_hold_left--;
          if (m_hold_left == 0) m_mode = arm ? 1 : 0;
        end
      endcase
      if (pulse_now != 0) m_esc = 0;
      m_prev_alert = alert ? 1 : 0;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (m_valid) begin
      chk("enable", enable, (m_mode == 1 || m_mode == 2) ? 1 : 0);
      chk("ring_led", ring_led, (m_mode == 2) ? 1 : 0);
      chk("buzzer", buzzer, (m_mode == 2 && ((m_ring - 1) % (BON + BOFF)) < BON) ? 1 : 0);
      chk("escalate", escalate, m_esc);
      chk("alert_cnt", alert_cnt, m_cnt);
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int beep_pat[4];
    int ack_pat[5];
    bit press;
    beep_pat = '{1, 0, 0, 1};
    ack_pat  = '{1, 0, 1, 1, 1};
    press = 1'b0;

    // Reset, arm, first alert episode and beep pattern.
    cyc(); cyc();
    chk("rst_enable", enable, 0);
    chk("rst_cnt", alert_cnt, 0);
    chk("rst_escalate", escalate, 0);
    rst = 1'b0; arm = 1'b1;
    cyc();
    chk("arm_enable", enable, 1);
    cyc(); cyc();
    alert = 1'b1;
    cyc();
    chk("ring_led_entry", ring_led, 1);
    chk("cnt_first", alert_cnt, 1);
    chk("beep_first", buzzer, 1);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("beep_pattern", buzzer, beep_pat[i]);
    end

    // Bouncy acknowledge then hold-off.
    for (int i = 0; i < 5; i++) begin
      ack_btn = ack_pat[i][0];
      cyc();
    end
    chk("ring_before_ack", ring_led, 1);
    ack_btn = 1'b0;
    cyc();
    chk("hold_ring_led", ring_led, 0);
    chk("hold_enable1", enable, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("hold_enable", enable, 0);
    end
    cyc();
    chk("rearm_enable", enable, 1);
    chk("no_escalate", escalate, 0);

    // Unacknowledged timeout, alert_off keeps escalate, ack clears it.
    alert = 1'b0; cyc();
    alert = 1'b1; cyc();
    chk("cnt_second", alert_cnt, 2);
    for (int i = 0; i < 19; i++) cyc();
    chk("esc_before", escalate, 0);
    cyc();
    chk("esc_set", escalate, 1);
    cyc(); cyc(); cyc();
    chk("esc_sticky", escalate, 1);
    chk("still_ringing", ring_led, 1);
    alert_off = 1'b1; cyc();
    alert_off = 1'b0;
    chk("aoff_hold", ring_led, 0);
    chk("aoff_esc_kept", escalate, 1);
    ack_btn = 1'b1; cyc(); cyc(); cyc();
    ack_btn = 1'b0; cyc();
    chk("ack_clears_esc", escalate, 0);

    // Reset mid-ringing with buzzer high.
    alert = 1'b0; cyc();
    alert = 1'b1; cyc();
    chk("pre_rst_buzzer", buzzer, 1);
    rst = 1'b1; cyc();
    chk("rst_mid_buzzer", buzzer, 0);
    chk("rst_mid_ring", ring_led, 0);
    chk("rst_mid_enable", enable, 0);
    chk("rst_mid_cnt", alert_cnt, 0);

    // Alert already high when arming must not ring.
    rst = 1'b0; arm = 1'b0; cyc();
    arm = 1'b1; cyc();
    chk("arm_with_alert", enable, 1);
    cyc(); cyc(); cyc();
    chk("held_alert_no_ring", ring_led, 0);
    alert = 1'b0; cyc();
    alert = 1'b1; cyc();
    chk("new_edge_rings", ring_led, 1);
    chk("cnt_after_rst", alert_cnt, 1);

    // Saturation over 16 episodes.
    for (int ep = 2; ep <= 16; ep++) begin
      alert_off = 1'b1; cyc();
      alert_off = 1'b0; alert = 1'b0;
      for (int i = 0; i < 4; i++) cyc();
      alert = 1'b1; cyc();
      chk("sat_cnt", alert_cnt, (ep < 15) ? ep : 15);
    end

    // Randomized traffic checked by the model.
    for (int n = 0; n < 4000; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 19) == 0) arm = ~arm;
      if ($urandom_range(0, 5) == 0) alert = ~alert;
      alert_off = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 39) == 0) press = ~press;
      ack_btn = press ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 14) == 0);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
